alu_issue_arbiter: RTL
======================

Name: alu_issue_arbiter

Overview:
- Round-robin arbiter that shares the single integer ALU among NUM_REQ reservation-station requesters in the out-of-order core.
- Each requester presents an already-decoded 4-bit ALU control code, two operands and a ROB tag.
- The block grants one requester per cycle and registers the winner into a one-entry issue stage with valid/ready backpressure toward the ALU/CDB.
- Supports a synchronous pipeline flush on branch mispredict.

Parameters:
- NUM_REQ, 4, number of requesting reservation stations (2..8).
- DATA_W, 32, operand width.
- TAG_W, 6, ROB tag width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of the issue stage and all same-cycle grants.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant (one-hot or zero).
- req_aluctrl  input  4*NUM_REQ  packed ALU control codes; requester i occupies bits [4i+3:4i].
- req_src1  input  DATA_W*NUM_REQ  packed operand 1.
- req_src2  input  DATA_W*NUM_REQ  packed operand 2.
- req_tag  input  TAG_W*NUM_REQ  packed ROB tags.
- iss_valid  output  1  issue stage holds a valid op.
- iss_ready  input  1  ALU/CDB accepts the op this cycle.
- iss_aluctrl  output  4  issued control code (0010 ADD, 0110 SUB, 0011 XOR, 0001 OR, 0111 SRA, 1111 pass/none).
- iss_src1  output  DATA_W  issued operand 1.
- iss_src2  output  DATA_W  issued operand 2.
- iss_tag  output  TAG_W  issued ROB tag.
- iss_src_id  output  clog2(NUM_REQ)  index of the requester that won.
- conflict_cnt  output  16  saturating count of cycles with at least one requester valid but not granted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - iss_valid=0; iss_aluctrl, iss_src1, iss_src2, iss_tag and iss_src_id all 0.
  - Round-robin pointer rr_ptr=0; conflict_cnt=0.
  - req_ready is forced to 0 while rst_n is low.
- Stage-open condition: stage_open = !iss_valid || iss_ready.
- Arbitration (combinational):
  - When stage_open && !flush, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[i]=1 only for the granted i; at most one bit is set.
  - Otherwise req_ready=0.
- Transfer: occurs when req_valid[i] && req_ready[i]. On that edge:
  - The issue register loads requester i's fields; iss_valid=1; iss_src_id=i.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Pointer hold: rr_ptr is unchanged in any cycle without a transfer.
- Drain: if iss_valid && iss_ready and there is no transfer, iss_valid <= 0 on the next edge.
- Back-to-back: if a transfer and a drain happen in the same cycle, the new op replaces the old one with no bubble, giving one op per cycle throughput.
- Stall: iss_valid && !iss_ready means req_ready=0 and all iss_* outputs hold stable.
- Latency: exactly 1 cycle from the transfer edge to iss_valid.
- Control codes:
  - No decode or modification. 1111 (LUI/no-ALU) is forwarded unchanged; downstream treats it as pass src2.
  - Any other unlisted code is also forwarded; illegal-code checking is not this block's job.
- Flush (sampled at the clock edge):
  - iss_valid <= 0 and req_ready=0 combinationally in the flush cycle, so no requester loses its op to a squashed grant.
  - rr_ptr is unchanged and conflict_cnt is unchanged.
  - Flush overrides iss_ready and pending transfers.
- conflict_cnt:
  - Increments by 1 on any edge where |(req_valid & ~req_ready) && !flush.
  - Saturates at 16'hFFFF and never wraps.
- Edge cases:
  - Requester withdrawal: a requester dropping req_valid before its grant is legal, and no state changes for it.
  - NUM_REQ not a power of two: the modulo wrap is explicit. For NUM_REQ=3, rr_ptr goes 2 -> 0, never 3.

Test Plan:
- Reset mid-stall: iss_valid=1, iss_ready=0, rst_n pulsed low asynchronously between edges -> iss_valid=0 immediately, rr_ptr=0, conflict_cnt=0, req_ready=0000 during reset.
- Single requester: req_valid=0010, aluctrl=0110, src1=0x0000_0009, src2=0x0000_0004, tag=5, iss_ready=1 -> req_ready=0010 in cycle 0; cycle 1 iss_valid=1, iss_aluctrl=0110, iss_tag=5, iss_src_id=1; rr_ptr=2.
- Fairness: all four valid continuously, iss_ready=1 -> grant order 0,1,2,3,0,1, one per cycle, no bubbles, conflict_cnt +1 every cycle.
- Backpressure: iss_ready=0 for 3 cycles with requests pending -> req_ready=0000, iss_* stable; iss_ready=1 -> next requester in RR order granted same cycle, loaded next edge.
- Flush: transfer pending from requester 2 with flush=1 -> req_ready=0000, iss_valid=0 next cycle, rr_ptr unchanged; next cycle without flush, requester 2 is granted.
- Pass-through/saturation: aluctrl=1111, src2=0xABCD_E000 -> iss_aluctrl=1111, iss_src2=0xABCD_E000. Force continuous conflict for 70000 cycles -> conflict_cnt=0xFFFF, no wrap.

Source files
------------

// File: rtl/alu_issue_arbiter_if.sv
// Request/issue bundle between the reservation stations, the ALU issue arbiter
// and the ALU/CDB consumer.
interface alu_issue_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // ready may depend on valid combinationally, valid never depends on ready.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [4*NUM_REQ-1:0]      req_aluctrl;
    logic [DATA_W*NUM_REQ-1:0] req_src1;
    logic [DATA_W*NUM_REQ-1:0] req_src2;
    logic [TAG_W*NUM_REQ-1:0]  req_tag;

    logic                      iss_valid;
    logic                      iss_ready;
    logic [3:0]                iss_aluctrl;
    logic [DATA_W-1:0]         iss_src1;
    logic [DATA_W-1:0]         iss_src2;
    logic [TAG_W-1:0]          iss_tag;
    logic [ID_W-1:0]           iss_src_id;

    modport slave (
        input  req_valid, req_aluctrl, req_src1, req_src2, req_tag, iss_ready,
        output req_ready, iss_valid, iss_aluctrl, iss_src1, iss_src2, iss_tag, iss_src_id
    );

    modport master (
        output req_valid, req_aluctrl, req_src1, req_src2, req_tag, iss_ready,
        input  req_ready, iss_valid, iss_aluctrl, iss_src1, iss_src2, iss_tag, iss_src_id
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing the integer ALU among reservation stations,
// feeding a one-entry issue register with valid/ready backpressure and flush.
module alu_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_issue_arbiter_if.slave  bus,
    output logic [15:0]         conflict_cnt,
    output logic [ID_W-1:0]     dbg_rr_ptr
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic [ID_W:0]      idx;
    logic               stage_open;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;

    assign stage_open = !bus.iss_valid || bus.iss_ready;
    assign dbg_rr_ptr = rr_ptr;

    // Scan from rr_ptr upward with an explicit wrap so non-power-of-two counts work.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (rst_n && found && stage_open && !flush) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign bus.req_ready = grant;
    assign xfer          = |(bus.req_valid & grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.iss_valid   <= 1'b0;
            bus.iss_aluctrl <= '0;
            bus.iss_src1    <= '0;
            bus.iss_src2    <= '0;
            bus.iss_tag     <= '0;
            bus.iss_src_id  <= '0;
            rr_ptr          <= '0;
        end else if (flush) begin
            bus.iss_valid <= 1'b0;
        end else if (xfer) begin
            bus.iss_valid   <= 1'b1;
            bus.iss_aluctrl <= bus.req_aluctrl[grant_id*4 +: 4];
            bus.iss_src1    <= bus.req_src1[grant_id*DATA_W +: DATA_W];
            bus.iss_src2    <= bus.req_src2[grant_id*DATA_W +: DATA_W];
            bus.iss_tag     <= bus.req_tag[grant_id*TAG_W +: TAG_W];
            bus.iss_src_id  <= grant_id;
            rr_ptr          <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end else if (bus.iss_ready) begin
            bus.iss_valid <= 1'b0;
        end
    end

    // Counts cycles where some valid requester went without a grant; sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (!flush && |(bus.req_valid & ~grant) && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule
